// File: rtl/mem_unit_pkg.sv
// Shared definitions for the memory unit: FSM states, access/command
// encodings and the layout of one request-queue entry.
package mem_unit_pkg;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 16;
   localparam int BYTE_W = 8;
   localparam int WIDTH_W = 1;
   localparam int CMD_W = 1;
   localparam int TAG_W = 1;

   localparam logic [WIDTH_W-1:0] W_BYTE = 1'b0;
   localparam logic [WIDTH_W-1:0] W_WORD = 1'b1;
   localparam logic [CMD_W-1:0] CMD_RD = 1'b0;
   localparam logic [CMD_W-1:0] CMD_WR = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LO,
      ST_HI,
      ST_RESP
   } state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic [WIDTH_W-1:0] width;
      logic [CMD_W-1:0] cmd;
      logic [TAG_W-1:0] tag;
   } rq_entry_t;

   // The high byte of a word lives at the next address, wrapping at 64K.
   function automatic logic [ADDR_W-1:0] next_byte_addr(input logic [ADDR_W-1:0] a);
      return a + 1'b1;
   endfunction

endpackage

// File: rtl/mem_unit_if.sv
// Signal bundle between the core (request/response side), the memory unit
// and the external byte-wide bus.
interface mem_unit_if;
   import mem_unit_pkg::*;

   logic [ADDR_W-1:0] mem_rq_addr;
   logic [DATA_W-1:0] mem_rq_data;
   logic mem_rq_prepare_addr;
   logic mem_rq_start;
   logic [WIDTH_W-1:0] mem_rq_width;
   logic [CMD_W-1:0] mem_rq_cmd;
   logic [TAG_W-1:0] mem_t_id;

   logic [DATA_W-1:0] mem_data_in;
   logic mem_data_wr;
   logic [TAG_W-1:0] mem_data_t_wr;
   logic mem_busy;
   logic rq_overflow;

   logic [ADDR_W-1:0] bus_addr;
   logic [BYTE_W-1:0] bus_dout;
   logic [BYTE_W-1:0] bus_din;
   logic bus_req;
   logic bus_we;
   logic bus_ack;

   // The master side is the core plus the external bus agent.
   modport master (
      output mem_rq_addr, mem_rq_data, mem_rq_prepare_addr, mem_rq_start,
             mem_rq_width, mem_rq_cmd, mem_t_id, bus_din, bus_ack,
      input  mem_data_in, mem_data_wr, mem_data_t_wr, mem_busy, rq_overflow,
             bus_addr, bus_dout, bus_req, bus_we
   );

   modport slave (
      input  mem_rq_addr, mem_rq_data, mem_rq_prepare_addr, mem_rq_start,
             mem_rq_width, mem_rq_cmd, mem_t_id, bus_din, bus_ack,
      output mem_data_in, mem_data_wr, mem_data_t_wr, mem_busy, rq_overflow,
             bus_addr, bus_dout, bus_req, bus_we
   );

endinterface

// File: rtl/mem_rq_fifo.sv
// Request queue: QDEPTH entries (power of two, >= 2) with wrapping
// read/write pointers and an occupancy count.
module mem_rq_fifo
   import mem_unit_pkg::*;
#(
   parameter int QDEPTH = 2
)
(
   input  logic clk,
   input  logic a_rst,
   input  logic push,
   input  rq_entry_t push_entry,
   input  logic pop,
   output rq_entry_t head,
   output logic full,
   output logic empty
);

   localparam int PW = $clog2(QDEPTH);
   localparam int CW = $clog2(QDEPTH + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(QDEPTH);

   rq_entry_t slots [QDEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic do_push;
   logic do_pop;

   // A push into a full queue is ignored here; the top reports the drop.
   assign do_push = push && !full;
   assign do_pop = pop && !empty;
   assign full = (count == FULL_CNT);
   assign empty = (count == '0);
   assign head = slots[rd_ptr];

   always_ff @(posedge clk) begin
      if (!a_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (do_push && !do_pop) begin
            count <= count + 1'b1;
         end else if (do_pop && !do_push) begin
            count <= count - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         slots[wr_ptr] <= push_entry;
      end
   end

endmodule

// File: rtl/mem_unit.sv
// Memory unit: queues core load/store requests and runs each one as one or
// two byte cycles on the external bus, returning tagged read results.
module mem_unit
   import mem_unit_pkg::*;
#(
   parameter int QDEPTH = 2
)
(
   input  logic clk,
   input  logic a_rst,
   mem_unit_if.slave mif
);

   state_t state;
   state_t state_next;

   logic [ADDR_W-1:0] mar;
   rq_entry_t rq_new;
   rq_entry_t head;
   logic q_full;
   logic q_empty;
   logic q_pop;
   logic q_push;

   logic [ADDR_W-1:0] act_addr;
   logic [DATA_W-1:0] act_data;
   logic [WIDTH_W-1:0] act_width;
   logic [CMD_W-1:0] act_cmd;
   logic [TAG_W-1:0] act_tag;
   logic [BYTE_W-1:0] rd_lo;
   logic [BYTE_W-1:0] rd_hi;
   logic [DATA_W-1:0] resp_data;

   logic [DATA_W-1:0] data_in_q;
   logic data_wr_q;
   logic [TAG_W-1:0] data_t_wr_q;
   logic overflow_q;

   logic bus_req_c;
   logic bus_we_c;
   logic [ADDR_W-1:0] bus_addr_c;
   logic [BYTE_W-1:0] bus_dout_c;

   // A same-cycle prepare bypasses MAR so the new address is used directly.
   always_comb begin
      rq_new = '0;
      rq_new.addr = mif.mem_rq_prepare_addr ? mif.mem_rq_addr : mar;
      rq_new.data = mif.mem_rq_data;
      rq_new.width = mif.mem_rq_width;
      rq_new.cmd = mif.mem_rq_cmd;
      rq_new.tag = mif.mem_t_id;
   end

   assign q_push = mif.mem_rq_start;

   mem_rq_fifo #(
      .QDEPTH (QDEPTH)
   ) u_fifo (
      .clk (clk),
      .a_rst (a_rst),
      .push (q_push),
      .push_entry (rq_new),
      .pop (q_pop),
      .head (head),
      .full (q_full),
      .empty (q_empty)
   );

   always_ff @(posedge clk) begin
      if (!a_rst) begin
         mar <= '0;
      end else if (mif.mem_rq_prepare_addr) begin
         mar <= mif.mem_rq_addr;
      end
   end

   always_ff @(posedge clk) begin
      if (!a_rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      q_pop = 1'b0;
      bus_req_c = 1'b0;
      bus_we_c = 1'b0;
      bus_addr_c = '0;
      bus_dout_c = '0;
      case (state)
         ST_IDLE: begin
            if (!q_empty) begin
               q_pop = 1'b1;
               state_next = ST_LO;
            end
         end
         ST_LO: begin
            bus_req_c = 1'b1;
            bus_we_c = act_cmd;
            bus_addr_c = act_addr;
            bus_dout_c = act_data[BYTE_W-1:0];
            if (mif.bus_ack) begin
               if (act_width == W_WORD) begin
                  state_next = ST_HI;
               end else if (act_cmd == CMD_RD) begin
                  state_next = ST_RESP;
               end else begin
                  state_next = ST_IDLE;
               end
            end
         end
         ST_HI: begin
            bus_req_c = 1'b1;
            bus_we_c = act_cmd;
            bus_addr_c = next_byte_addr(act_addr);
            bus_dout_c = act_data[DATA_W-1:BYTE_W];
            if (mif.bus_ack) begin
               state_next = (act_cmd == CMD_RD) ? ST_RESP : ST_IDLE;
            end
         end
         ST_RESP: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Active request registers; read bytes are captured on every ack.
   always_ff @(posedge clk) begin
      if (!a_rst) begin
         act_addr <= '0;
         act_data <= '0;
         act_width <= '0;
         act_cmd <= '0;
         act_tag <= '0;
         rd_lo <= '0;
         rd_hi <= '0;
      end else begin
         if (q_pop) begin
            act_addr <= head.addr;
            act_data <= head.data;
            act_width <= head.width;
            act_cmd <= head.cmd;
            act_tag <= head.tag;
            rd_lo <= '0;
            rd_hi <= '0;
         end
         if (state == ST_LO && mif.bus_ack) begin
            rd_lo <= mif.bus_din;
         end
         if (state == ST_HI && mif.bus_ack) begin
            rd_hi <= mif.bus_din;
         end
      end
   end

   assign resp_data = (act_width == W_WORD) ? {rd_hi, rd_lo} : {{BYTE_W{1'b0}}, rd_lo};

   // Response and overflow outputs are registered, so the strobe trails RESP by one edge.
   always_ff @(posedge clk) begin
      if (!a_rst) begin
         data_in_q <= '0;
         data_wr_q <= 1'b0;
         data_t_wr_q <= '0;
         overflow_q <= 1'b0;
      end else begin
         overflow_q <= mif.mem_rq_start && q_full;
         data_wr_q <= (state == ST_RESP);
         if (state == ST_RESP) begin
            data_in_q <= resp_data;
            data_t_wr_q <= act_tag;
         end
      end
   end

   assign mif.mem_data_in = data_in_q;
   assign mif.mem_data_wr = data_wr_q;
   assign mif.mem_data_t_wr = data_t_wr_q;
   assign mif.rq_overflow = overflow_q;
   assign mif.mem_busy = q_full;
   assign mif.bus_req = bus_req_c;
   assign mif.bus_we = bus_we_c;
   assign mif.bus_addr = bus_addr_c;
   assign mif.bus_dout = bus_dout_c;

endmodule

// File: tb/tb_mem_unit.sv
// Self-checking bench for mem_unit: directed scenarios plus randomized traffic
// against a transaction-level model of expected bus beats and read responses.
module tb_mem_unit;
   import mem_unit_pkg::*;

   localparam int QDEPTH = 2;

   typedef struct {
      logic [15:0] addr;
      logic we;
      logic [7:0] dout;
   } bus_beat_t;

   typedef struct {
      logic [15:0] data;
      logic tag;
   } resp_t;

   logic clk = 1'b0;
   logic a_rst = 1'b0;

   mem_unit_if mif ();

   mem_unit #(.QDEPTH(QDEPTH)) dut (
      .clk (clk),
      .a_rst (a_rst),
      .mif (mif)
   );

   always #5 clk = ~clk;

   int checkCount = 0;
   int failCount = 0;
   int cyc = 0;
   bus_beat_t expBus[$];
   resp_t expResp[$];
   logic [7:0] memByte [0:65535];
   logic [15:0] modelMar = '0;
   int fixedWait = 0;
   int ackLimit = -1;
   int ackCount = 0;
   int waitCnt = 0;
   logic reqSeen = 1'b0;
   logic ovfArm = 1'b0;
   logic ovfExp = 1'b0;
   int startCyc = 0;
   int reqCyc = 0;
   int strobeCyc = 0;
   logic [15:0] lastResp = '0;
   logic lastTag = 1'b0;
   int beatsBefore = 0;
   int spin = 0;
   logic rPrep, rStart, rWidth, rCmd, rTag;
   logic [15:0] rAddr, rData;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, observed, expected, cyc);
      end
   endtask

   function automatic int pickWait();
      return (fixedWait >= 0) ? fixedWait : int'($urandom_range(0, 3));
   endfunction

   // One cycle of core-side stimulus; records what the model expects to follow.
   task automatic applyStimulus(input logic prep, input logic start, input logic [15:0] addr,
                                input logic [15:0] data, input logic width, input logic cmd,
                                input logic tid, input logic accept, input logic gate);
      logic doStart;
      logic [15:0] a;
      logic [15:0] a1;
      @(negedge clk);
      doStart = start && !(gate && mif.mem_busy);
      mif.mem_rq_prepare_addr = prep;
      mif.mem_rq_start = doStart;
      mif.mem_rq_addr = addr;
      mif.mem_rq_data = data;
      mif.mem_rq_width = width;
      mif.mem_rq_cmd = cmd;
      mif.mem_t_id = tid;
      ovfArm = doStart && !accept;
      if (doStart) startCyc = cyc;
      if (doStart && accept) begin
         a = prep ? addr : modelMar;
         a1 = a + 16'd1;
         expBus.push_back('{addr: a, we: cmd, dout: data[7:0]});
         if (width == W_WORD) expBus.push_back('{addr: a1, we: cmd, dout: data[15:8]});
         if (cmd == CMD_RD) begin
            if (width == W_WORD) expResp.push_back('{data: {memByte[a1], memByte[a]}, tag: tid});
            else expResp.push_back('{data: {8'h00, memByte[a]}, tag: tid});
         end
      end
      if (prep) modelMar = addr;
   endtask

   task automatic idle();
      applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, W_BYTE, CMD_RD, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic waitDrain(input string tag, input int bound);
      int n;
      n = 0;
      while ((expBus.size() != 0 || expResp.size() != 0) && n < bound) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      checkOutput({tag, "_pending"}, 32'(expBus.size() + expResp.size()), 32'd0);
   endtask

   // Bus agent: inserts wait states, serves bytes from memByte and checks each beat.
   always @(negedge clk) begin
      if (!a_rst || !mif.bus_req) begin
         mif.bus_ack = 1'b0;
         reqSeen = 1'b0;
         waitCnt = pickWait();
      end else begin
         if (!reqSeen) begin
            reqSeen = 1'b1;
            reqCyc = cyc;
         end
         if (expBus.size() == 0) begin
            checkOutput("bus_unexpected", 32'(mif.bus_req), 32'd0);
            mif.bus_ack = 1'b0;
         end else begin
            checkOutput("bus_addr", 32'(mif.bus_addr), 32'(expBus[0].addr));
            checkOutput("bus_we", 32'(mif.bus_we), 32'(expBus[0].we));
            checkOutput("bus_dout", 32'(mif.bus_dout), 32'(expBus[0].dout));
            if (waitCnt == 0 && (ackLimit < 0 || ackCount < ackLimit)) begin
               mif.bus_ack = 1'b1;
               mif.bus_din = memByte[mif.bus_addr];
               void'(expBus.pop_front());
               ackCount++;
               waitCnt = pickWait();
            end else begin
               mif.bus_ack = 1'b0;
               mif.bus_din = 8'($urandom);
               if (waitCnt > 0) waitCnt--;
            end
         end
      end
   end

   // Response and overflow monitor, sampled just after each rising edge.
   always @(posedge clk) begin
      resp_t r;
      ovfExp = ovfArm && a_rst;
      #1;
      checkOutput("rq_overflow", 32'(mif.rq_overflow), 32'(ovfExp));
      if (mif.mem_data_wr === 1'b1) begin
         strobeCyc = cyc;
         lastResp = mif.mem_data_in;
         lastTag = mif.mem_data_t_wr;
         if (expResp.size() == 0) begin
            checkOutput("resp_unexpected", 32'(mif.mem_data_wr), 32'd0);
         end else begin
            r = expResp.pop_front();
            checkOutput("resp_data", 32'(mif.mem_data_in), 32'(r.data));
            checkOutput("resp_tag", 32'(mif.mem_data_t_wr), 32'(r.tag));
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      for (int i = 0; i < 65536; i++) memByte[i] = i[7:0] ^ i[15:8] ^ 8'h5A;
      mif.mem_rq_prepare_addr = 1'b0;
      mif.mem_rq_start = 1'b0;
      mif.mem_rq_addr = '0;
      mif.mem_rq_data = '0;
      mif.mem_rq_width = W_BYTE;
      mif.mem_rq_cmd = CMD_RD;
      mif.mem_t_id = 1'b0;
      a_rst = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst_data_in", 32'(mif.mem_data_in), 32'd0);
      checkOutput("rst_data_wr", 32'(mif.mem_data_wr), 32'd0);
      checkOutput("rst_data_t_wr", 32'(mif.mem_data_t_wr), 32'd0);
      checkOutput("rst_busy", 32'(mif.mem_busy), 32'd0);
      checkOutput("rst_overflow", 32'(mif.rq_overflow), 32'd0);
      checkOutput("rst_bus_req", 32'(mif.bus_req), 32'd0);
      checkOutput("rst_bus_we", 32'(mif.bus_we), 32'd0);
      checkOutput("rst_bus_addr", 32'(mif.bus_addr), 32'd0);
      checkOutput("rst_bus_dout", 32'(mif.bus_dout), 32'd0);
      a_rst = 1'b1;
      idle();

      $display("[TB] byte read, zero wait");
      fixedWait = 0;
      memByte[16'h1234] = 8'hAB;
      applyStimulus(1'b1, 1'b1, 16'h1234, 16'h0000, W_BYTE, CMD_RD, 1'b1, 1'b1, 1'b0);
      idle();
      waitDrain("byte_rd", 50);
      checkOutput("lat_bus_req", 32'(reqCyc - startCyc), 32'd2);
      checkOutput("lat_byte_rd", 32'(strobeCyc - startCyc), 32'd4);
      checkOutput("byte_rd_data", 32'(lastResp), 32'h00AB);
      checkOutput("byte_rd_tag", 32'(lastTag), 32'd1);

      $display("[TB] word read across address wrap");
      memByte[16'hFFFF] = 8'h34;
      memByte[16'h0000] = 8'h12;
      applyStimulus(1'b1, 1'b1, 16'hFFFF, 16'h0000, W_WORD, CMD_RD, 1'b0, 1'b1, 1'b0);
      idle();
      waitDrain("word_rd", 50);
      checkOutput("lat_word_rd", 32'(strobeCyc - startCyc), 32'd5);
      checkOutput("word_rd_data", 32'(lastResp), 32'h1234);
      checkOutput("word_rd_tag", 32'(lastTag), 32'd0);

      $display("[TB] word write with wait states");
      fixedWait = 3;
      beatsBefore = ackCount;
      applyStimulus(1'b1, 1'b1, 16'h0200, 16'hBEEF, W_WORD, CMD_WR, 1'b0, 1'b1, 1'b0);
      idle();
      waitDrain("word_wr", 80);
      checkOutput("word_wr_beats", 32'(ackCount - beatsBefore), 32'd2);

      $display("[TB] queue full and overflow");
      fixedWait = 0;
      ackLimit = ackCount;
      applyStimulus(1'b1, 1'b1, 16'h0100, 16'h0000, W_BYTE, CMD_RD, 1'b0, 1'b1, 1'b0);
      idle();
      spin = 0;
      while (!mif.bus_req && spin < 20) begin
         @(negedge clk);
         spin++;
      end
      checkOutput("ovf_inflight", 32'(mif.bus_req), 32'd1);
      applyStimulus(1'b1, 1'b1, 16'h0110, 16'h0000, W_BYTE, CMD_RD, 1'b1, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b1, 16'h0120, 16'h0000, W_WORD, CMD_RD, 1'b0, 1'b1, 1'b0);
      checkOutput("busy_after_1st", 32'(mif.mem_busy), 32'd0);
      applyStimulus(1'b1, 1'b1, 16'h0130, 16'h0000, W_BYTE, CMD_RD, 1'b1, 1'b0, 1'b0);
      checkOutput("busy_after_2nd", 32'(mif.mem_busy), 32'd1);
      idle();
      checkOutput("busy_after_drop", 32'(mif.mem_busy), 32'd1);
      checkOutput("ovf_pulse", 32'(mif.rq_overflow), 32'd1);
      idle();
      checkOutput("ovf_single", 32'(mif.rq_overflow), 32'd0);
      ackLimit = -1;
      waitDrain("ovf_drain", 100);
      checkOutput("busy_drained", 32'(mif.mem_busy), 32'd0);

      $display("[TB] reset during the high byte of a word read");
      ackLimit = ackCount + 1;
      applyStimulus(1'b1, 1'b1, 16'h3000, 16'h0000, W_WORD, CMD_RD, 1'b1, 1'b1, 1'b0);
      idle();
      spin = 0;
      while (ackCount < ackLimit && spin < 20) begin
         @(negedge clk);
         spin++;
      end
      @(negedge clk);
      checkOutput("hi_bus_req", 32'(mif.bus_req), 32'd1);
      checkOutput("hi_bus_addr", 32'(mif.bus_addr), 32'h3001);
      a_rst = 1'b0;
      expBus.delete();
      expResp.delete();
      modelMar = '0;
      @(negedge clk);
      checkOutput("rst_mid_bus_req", 32'(mif.bus_req), 32'd0);
      checkOutput("rst_mid_data_wr", 32'(mif.mem_data_wr), 32'd0);
      checkOutput("rst_mid_busy", 32'(mif.mem_busy), 32'd0);
      a_rst = 1'b1;
      ackLimit = -1;
      repeat (6) @(negedge clk);

      $display("[TB] prepare and start together bypass MAR");
      applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0000, W_BYTE, CMD_RD, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b1, 16'h0042, 16'h0000, W_BYTE, CMD_RD, 1'b1, 1'b1, 1'b0);
      idle();
      waitDrain("bypass", 50);
      checkOutput("bypass_data", 32'(lastResp), 32'({8'h00, memByte[16'h0042]}));
      applyStimulus(1'b0, 1'b1, 16'h0099, 16'h5577, W_WORD, CMD_RD, 1'b0, 1'b1, 1'b0);
      idle();
      waitDrain("use_mar", 50);

      $display("[TB] randomized traffic");
      fixedWait = -1;
      for (int it = 0; it < 400; it++) begin
         rPrep = ($urandom_range(0, 2) == 0);
         rStart = ($urandom_range(0, 1) == 1);
         rAddr = 16'($urandom);
         rData = 16'($urandom);
         rWidth = 1'($urandom);
         rCmd = 1'($urandom);
         rTag = 1'($urandom);
         applyStimulus(rPrep, rStart, rAddr, rData, rWidth, rCmd, rTag, 1'b1, 1'b1);
      end
      idle();
      waitDrain("random", 3000);
      checkOutput("final_busy", 32'(mif.mem_busy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule

// File: doc/mem_unit.md
MEM_UNIT -- requirements
Module: mem_unit

Interface
REQ-001 Parameter: QDEPTH, 2, request-queue depth in entries; power of two, at least 2.
REQ-002 Port: clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 Port: a_rst  in  1  reset; synchronous, active-low.
REQ-004 Port: mem_rq_addr  in  16  address from the core ALU MAR path.
REQ-005 Port: mem_rq_data  in  16  store data.
REQ-006 Port: mem_rq_prepare_addr  in  1  latch mem_rq_addr into the internal MAR.
REQ-007 Port: mem_rq_start  in  1  enqueue a request.
REQ-008 Port: mem_rq_width  in  1  access width; 0 = byte, 1 = word.
REQ-009 Port: mem_rq_cmd  in  1  command; 0 = read, 1 = write.
REQ-010 Port: mem_t_id  in  1  tag of the requesting reservation station; 0 = rsa, 1 = rsb.
REQ-011 Port: mem_data_in  out  16  read result to the stations.
REQ-012 Port: mem_data_wr  out  1  read-result valid strobe, one cycle.
REQ-013 Port: mem_data_t_wr  out  1  tag of the returned result.
REQ-014 Port: mem_busy  out  1  queue full; drives core hold.
REQ-015 Port: rq_overflow  out  1  one-cycle pulse when a start is dropped.
REQ-016 Port: bus_addr  out  16  external byte address.
REQ-017 Port: bus_dout  out  8  external write byte.
REQ-018 Port: bus_din  in  8  external read byte.
REQ-019 Port: bus_req  out  1  external cycle request.
REQ-020 Port: bus_we  out  1  external write enable.
REQ-021 Port: bus_ack  in  1  byte transfer complete; sampled while bus_req = 1.

Function
REQ-022 MAR SHALL load mem_rq_addr when mem_rq_prepare_addr = 1.
REQ-023 An enqueued entry SHALL hold {address, data, width, cmd, tag}; its address is mem_rq_addr when prepare and start are both 1 in the same cycle, otherwise MAR.
REQ-024 mem_busy SHALL equal (queue count == QDEPTH), combinationally.
REQ-025 A start while the queue is full SHALL be dropped and SHALL pulse rq_overflow the next cycle, even if a pop occurs in that same cycle.
REQ-026 Enqueue and pop in the same cycle on a non-full queue SHALL leave the count unchanged.
REQ-027 The FSM SHALL have states IDLE, LO, HI and RESP.
REQ-028 IDLE SHALL pop the head entry into the active registers when the queue is non-empty, then go to LO.
REQ-029 In LO, bus_req = 1, bus_addr = A and bus_dout = data[7:0]; on bus_ack: a word access goes to HI; a byte read goes to RESP; a byte write goes to IDLE.
REQ-030 In HI, bus_addr = A+1 with 16-bit wrap (0xFFFF -> 0x0000) and bus_dout = data[15:8]; on bus_ack: a read goes to RESP, a write goes to IDLE.
REQ-031 bus_addr, bus_dout, bus_we and bus_req SHALL stay stable in LO and HI until bus_ack is sampled; wait states are unbounded.
REQ-032 Read data SHALL be captured on each ack; a byte read returns {8'h00, lo}, a word read returns {hi, lo} (little-endian).
REQ-033 RESP SHALL assert mem_data_wr for exactly one cycle with mem_data_in and mem_data_t_wr valid, then go to IDLE.
REQ-034 Writes SHALL produce no mem_data_wr.
REQ-035 Latency from a start in cycle N on an empty, idle unit with zero-wait ack: bus_req in N+2; byte read strobe in N+4; word read strobe in N+5.
REQ-036 bus_req SHALL be 0 in IDLE and RESP; bus_we = active cmd in LO and HI, otherwise 0.
REQ-037 Requests SHALL complete strictly in queue order.

Reset
REQ-038 While a_rst = 0, at the next edge the unit SHALL clear the state to IDLE, the queue to empty, MAR to 0 and the active registers to 0.
REQ-039 Reset values: mem_data_in = 0, mem_data_wr = 0, mem_data_t_wr = 0, mem_busy = 0, rq_overflow = 0, bus_req = 0, bus_we = 0, bus_addr = 0, bus_dout = 0.
REQ-040 Reset asserted mid-transaction SHALL drop bus_req the following cycle and SHALL suppress any pending response.

Structure
REQ-041 A shared package SHALL hold the FSM state encoding, the width constants (W_BYTE, W_WORD), the command constants (CMD_RD, CMD_WR) and the queue-entry field widths.
REQ-042 The queue SHALL be a sub-module mem_rq_fifo (parameterised depth, count, wrapping pointers); the FSM and datapath SHALL stay in mem_unit.

Verification
REQ-043 Byte read: addr 0x1234, tag 1, zero-wait ack, bus_din = 0xAB -> single bus cycle at 0x1234; mem_data_in = 0x00AB, mem_data_t_wr = 1.
REQ-044 Word read across the wrap: addr 0xFFFF, bytes 0x34 then 0x12 -> bus addresses 0xFFFF then 0x0000; mem_data_in = 0x1234.
REQ-045 Word write: addr 0x0200, data 0xBEEF, 3 wait cycles per byte -> bus_dout 0xEF at 0x0200, then 0xBE at 0x0201, both held stable; no mem_data_wr.
REQ-046 Overflow: QDEPTH = 2, bus_ack held 0, three starts -> mem_busy = 1 after the 2nd start; 3rd start dropped with rq_overflow pulse; releasing ack serves two requests in order.
REQ-047 Reset in HI of a word read -> bus_req = 0 the next cycle; no mem_data_wr; queue empty; a subsequent read behaves normally.
REQ-048 Prepare and start in the same cycle with addr 0x0042 while MAR holds 0x0010 -> bus access targets 0x0042.
